// File: rtl/jt900h_irqgen_pkg.sv
// Shared definitions for the jt900h interrupt/DMA request generator:
// control/status field positions, idle count value and vector helper.
package jt900h_irqgen_pkg;

  localparam int unsigned CNT_MSB = 15;
  localparam int unsigned CNT_LSB = 8;
  localparam int unsigned DMA_BIT = 7;
  localparam int unsigned IRQ_BIT = 6;
  localparam int unsigned CH_MSB  = 5;
  localparam int unsigned CH_LSB  = 4;
  localparam int unsigned OVF_BIT = 3;
  localparam int unsigned LVL_MSB = 2;
  localparam int unsigned LVL_LSB = 0;

  // Bit 8 set marks the counter as stopped.
  localparam logic [8:0] CNT_IDLE = 9'h1ff;

  typedef struct packed {
    logic [7:0] cnt;
    logic       dmaen;
    logic       irq;
    logic [1:0] dmach;
    logic       ovf;
    logic [2:0] lvl;
  } status_t;

  function automatic logic [7:0] vector_addr(input logic [2:0] lvl);
    return {3'd1, lvl, 2'd0};
  endfunction

endpackage

// File: rtl/jt900h_irqgen_cnt.sv
// 9-bit countdown: load, optional auto-reload on expiry, stop request,
// and a single-cycle expiry indication while enabled.
module jt900h_irqgen_cnt
  import jt900h_irqgen_pkg::*;
(
  input  logic       rst,
  input  logic       clk,
  input  logic       cen,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       stop,
  input  logic       reload,
  input  logic [7:0] rld,
  output logic [8:0] cnt,
  output logic       expire
);

  assign expire = cen & ~cnt[8] & (cnt[7:0] == '0);

  // Load beats stop, stop beats the natural expiry/decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= CNT_IDLE;
    end else if (cen) begin
      if (load) begin
        cnt <= {1'b0, load_val};
      end else if (stop) begin
        cnt[8] <= 1'b1;
      end else if (!cnt[8]) begin
        if (cnt[7:0] == '0)
          cnt <= reload ? {1'b0, rld} : CNT_IDLE;
        else
          cnt <= cnt - 9'd1;
      end
    end
  end

endmodule

// File: rtl/jt900h_irqgen.sv
// Memory-mapped interrupt/DMA request responder for the jt900h CPU:
// programmable countdown raising irq at a set level, optional periodic reload.
module jt900h_irqgen
  import jt900h_irqgen_pkg::*;
#(
  parameter logic [22:0] ADDR   = 23'h7ff8,
  parameter logic [2:0]  DMALVL = 3'd6
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic [22:0] addr,
  input  logic [15:0] din,
  input  logic [1:0]  we,
  input  logic        rd,
  output logic [15:0] dout,
  output logic        irq,
  input  logic        irq_ack,
  output logic [2:0]  int_lvl,
  output logic [7:0]  int_addr,
  output logic [1:0]  dmach,
  output logic        dmaen,
  input  logic        dma_done
);

  logic       hit;
  logic       wr;
  logic       wr_cnt;
  logic [7:0] rld;
  logic [2:0] lvl;
  logic       ovf;
  logic [8:0] cnt;
  logic       expire;
  status_t    status;

  assign hit    = (addr == ADDR);
  assign wr     = hit & (|we);
  assign wr_cnt = hit & we[1];

  jt900h_irqgen_cnt u_cnt (
    .rst      (rst),
    .clk      (clk),
    .cen      (cen),
    .load     (wr_cnt),
    .load_val (din[CNT_MSB:CNT_LSB]),
    .stop     (dma_done),
    .reload   (dmaen),
    .rld      (rld),
    .cnt      (cnt),
    .expire   (expire)
  );

  assign status   = {cnt[7:0], dmaen, irq, dmach, ovf, lvl};
  assign int_lvl  = dmaen ? DMALVL : lvl;
  assign int_addr = vector_addr(int_lvl);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmaen <= 1'b0;
      dmach <= '0;
      lvl   <= '0;
      rld   <= '0;
      irq   <= 1'b0;
      ovf   <= 1'b0;
      dout  <= '0;
    end else if (cen) begin
      if (wr && we[0]) begin
        dmaen <= din[DMA_BIT];
        dmach <= din[CH_MSB:CH_LSB];
        lvl   <= din[LVL_MSB:LVL_LSB];
      end
      if (wr_cnt)
        rld <= din[CNT_MSB:CNT_LSB];
      else if (dma_done)
        rld <= '0;
      // An expiry while irq is still pending is recorded as an overrun.
      if (wr) begin
        irq <= 1'b0;
        ovf <= 1'b0;
      end else if (expire) begin
        irq <= 1'b1;
        ovf <= irq;
      end else if (irq_ack) begin
        irq <= 1'b0;
      end
      dout <= (hit && rd) ? status : '0;
    end
  end

endmodule

// File: tb/tb_jt900h_irqgen.sv
// Self-checking bench for jt900h_irqgen: directed vector table, hand
// sequences for multi-cycle corners, and random traffic against a model.
module tb_jt900h_irqgen;
  import jt900h_irqgen_pkg::*;

  localparam logic [22:0] ADDR   = 23'h7ff8;
  localparam logic [2:0]  DMALVL = 3'd6;

  logic        rst, clk, cen, rd, irq, irq_ack, dmaen, dma_done;
  logic [22:0] addr;
  logic [15:0] din, dout;
  logic [1:0]  we, dmach;
  logic [2:0]  int_lvl;
  logic [7:0]  int_addr;

  jt900h_irqgen #(.ADDR(ADDR), .DMALVL(DMALVL)) dut (
    .rst(rst), .clk(clk), .cen(cen), .addr(addr), .din(din), .we(we),
    .rd(rd), .dout(dout), .irq(irq), .irq_ack(irq_ack), .int_lvl(int_lvl),
    .int_addr(int_addr), .dmach(dmach), .dmaen(dmaen), .dma_done(dma_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: "active" flag plus remaining count, following the
  // documented register rules directly.
  bit        m_act;
  bit [7:0]  m_cnt, m_rld;
  bit        m_irq, m_ovf, m_dmaen;
  bit [1:0]  m_dmach;
  bit [2:0]  m_lvl;
  bit [15:0] m_dout;

  task automatic m_reset();
    m_act = 0; m_cnt = 8'hff; m_rld = 0; m_irq = 0; m_ovf = 0;
    m_dmaen = 0; m_dmach = 0; m_lvl = 0; m_dout = 0;
  endtask

  task automatic m_step(input bit c, input bit h, input bit [1:0] w, input bit [15:0] d,
                        input bit r, input bit a, input bit dn);
    bit expire, write;
    bit n_act, n_irq, n_ovf, n_dmaen;
    bit [7:0] n_cnt, n_rld;
    bit [1:0] n_dmach;
    bit [2:0] n_lvl;
    if (!c) return;
    expire = m_act && (m_cnt == 0);
    write  = h && (w != 0);
    m_dout = (h && r) ? {m_cnt, m_dmaen, m_irq, m_dmach, m_ovf, m_lvl} : 16'h0;
    n_irq = write ? 1'b0 : expire ? 1'b1 : a ? 1'b0 : m_irq;
    n_ovf = write ? 1'b0 : expire ? m_irq : m_ovf;
    n_act = m_act; n_cnt = m_cnt;
    if (h && w[1]) begin n_act = 1; n_cnt = d[15:8]; end
    else if (dn) n_act = 0;
    else if (expire) begin
      if (m_dmaen) n_cnt = m_rld;
      else begin n_act = 0; n_cnt = 8'hff; end
    end else if (m_act) n_cnt = m_cnt - 8'd1;
    n_rld = (h && w[1]) ? d[15:8] : dn ? 8'h00 : m_rld;
    n_dmaen = m_dmaen; n_dmach = m_dmach; n_lvl = m_lvl;
    if (h && w[0]) begin n_dmaen = d[7]; n_dmach = d[5:4]; n_lvl = d[2:0]; end
    m_act = n_act; m_cnt = n_cnt; m_rld = n_rld; m_irq = n_irq; m_ovf = n_ovf;
    m_dmaen = n_dmaen; m_dmach = n_dmach; m_lvl = n_lvl;
  endtask

  // One clock: drive at negedge, model + compare just after posedge.
  task automatic tick(input bit c, input bit h, input bit [1:0] w, input bit [15:0] d,
                      input bit r, input bit a, input bit dn);
    logic [22:0] oa;
    bit [2:0] el;
    oa = 23'($urandom);
    if (oa == ADDR) oa = oa ^ 23'd1;
    cen = c; addr = h ? ADDR : oa; we = w; din = d; rd = r; irq_ack = a; dma_done = dn;
    @(posedge clk);
    m_step(c, h, w, d, r, a, dn);
    #1;
    el = m_dmaen ? DMALVL : m_lvl;
    chk("model", {1'b0, irq, int_lvl, int_addr, dmach, dmaen, dout},
        {1'b0, m_irq, el, 8'(32 + 4 * int'(el)), m_dmach, m_dmaen, m_dout});
    @(negedge clk);
  endtask

  typedef struct {
    bit [1:0]  we;
    bit [15:0] din;
    bit        rd;
    bit        ack;
    bit        e_irq;
    bit [2:0]  e_lvl;
    bit [15:0] e_dout;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst = 1; cen = 0; addr = '0; din = '0; we = '0; rd = 0; irq_ack = 0; dma_done = 0;
    m_reset();
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("reset", {irq, int_lvl, int_addr, dmach, dmaen, dout}, {1'b0, 3'd0, 8'h20, 2'd0, 1'b0, 16'h0});
    rst = 0;

    // Single-shot count of 5, ack, then byte-lane writes.
    tbl.push_back('{2'b11, 16'h0503, 0, 0, 0, 3, 16'h0000});
    for (int i = 0; i < 5; i++) tbl.push_back('{2'b00, 16'h0, 0, 0, 0, 3, 16'h0000});
    tbl.push_back('{2'b00, 16'h0000, 0, 0, 1, 3, 16'h0000});
    tbl.push_back('{2'b00, 16'h0000, 1, 0, 1, 3, 16'hff43});
    tbl.push_back('{2'b00, 16'h0000, 0, 1, 0, 3, 16'h0000});
    for (int i = 0; i < 3; i++) tbl.push_back('{2'b00, 16'h0, 0, 0, 0, 3, 16'h0000});
    tbl.push_back('{2'b01, 16'hff05, 0, 0, 0, 5, 16'h0000});
    tbl.push_back('{2'b00, 16'h0000, 1, 0, 0, 5, 16'hff05});
    tbl.push_back('{2'b00, 16'h0000, 0, 0, 0, 5, 16'h0000});
    tbl.push_back('{2'b00, 16'h0000, 0, 0, 0, 5, 16'h0000});
    tbl.push_back('{2'b00, 16'h0000, 1, 0, 0, 5, 16'hff05});
    tbl.push_back('{2'b10, 16'h02ab, 0, 0, 0, 5, 16'h0000});
    tbl.push_back('{2'b00, 16'h0000, 1, 0, 0, 5, 16'h0205});
    tbl.push_back('{2'b00, 16'h0000, 0, 0, 0, 5, 16'h0000});
    tbl.push_back('{2'b00, 16'h0000, 0, 0, 1, 5, 16'h0000});
    tbl.push_back('{2'b00, 16'h0000, 0, 1, 0, 5, 16'h0000});
    for (int i = 0; i < tbl.size(); i++) begin
      tick(1, 1, tbl[i].we, tbl[i].din, tbl[i].rd, tbl[i].ack, 0);
      chk($sformatf("vec%0d", i), {irq, int_lvl, dout}, {tbl[i].e_irq, tbl[i].e_lvl, tbl[i].e_dout});
    end

    // Periodic DMA trigger every 4 cen, then dma_done stops it.
    tick(1, 1, 2'b11, 16'h03b0, 0, 0, 0);
    chk("dma_cfg", {dmaen, dmach, int_lvl, int_addr}, {1'b1, 2'd3, 3'd6, 8'h38});
    for (int p = 0; p < 3; p++)
      for (int k = 1; k <= 4; k++) begin
        tick(1, 1, 2'b00, 16'h0, 0, (k == 1) && (p > 0), 0);
        chk($sformatf("dma_p%0d_k%0d", p, k), irq, (k == 4));
      end
    tick(1, 1, 2'b00, 16'h0, 0, 1, 1);
    chk("dma_done_ack", irq, 0);
    for (int i = 0; i < 6; i++) begin
      tick(1, 1, 2'b00, 16'h0, 0, 0, 0);
      chk("dma_stopped", irq, 0);
    end
    tick(1, 1, 2'b00, 16'h0, 1, 0, 0);
    chk("dma_rd1", dout, 16'h03b0);
    for (int i = 0; i < 3; i++) tick(1, 1, 2'b00, 16'h0, 0, 0, 0);
    tick(1, 1, 2'b00, 16'h0, 1, 0, 0);
    chk("dma_rd2", dout, 16'h03b0);

    // Overrun: DMA mode, irq never acknowledged.
    tick(1, 1, 2'b11, 16'h0180, 0, 0, 0);
    tick(1, 1, 2'b00, 16'h0, 0, 0, 0);
    tick(1, 1, 2'b00, 16'h0, 0, 0, 0);
    chk("ovf_first", irq, 1);
    tick(1, 1, 2'b00, 16'h0, 0, 0, 0);
    tick(1, 1, 2'b00, 16'h0, 0, 0, 0);
    tick(1, 1, 2'b00, 16'h0, 1, 0, 0);
    chk("ovf_read", dout, 16'h01c8);
    tick(1, 1, 2'b01, 16'h0000, 0, 0, 0);
    chk("ovf_wr_irq", irq, 0);
    tick(1, 1, 2'b00, 16'h0, 1, 0, 0);
    chk("ovf_cleared", {dout[IRQ_BIT], dout[OVF_BIT]}, 0);

    // Zero count, and a write landing on the expiry edge.
    tick(1, 1, 2'b11, 16'h0000, 0, 0, 0);
    tick(1, 1, 2'b00, 16'h0, 0, 0, 0);
    chk("zero_cnt", irq, 1);
    tick(1, 1, 2'b11, 16'h0000, 0, 0, 0);
    tick(1, 1, 2'b11, 16'h0200, 0, 0, 0);
    chk("wr_on_expiry", irq, 0);
    for (int k = 1; k <= 3; k++) begin
      tick(1, 1, 2'b00, 16'h0, 0, 0, 0);
      chk($sformatf("reload_k%0d", k), irq, (k == 3));
    end

    // cen=0 freeze, then asynchronous reset mid-count with irq high.
    tick(1, 1, 2'b11, 16'h0400, 0, 0, 0);
    tick(1, 1, 2'b00, 16'h0, 0, 0, 0);
    tick(1, 1, 2'b00, 16'h0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      tick(0, 1, 2'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    chk("frozen_irq", irq, 0);
    for (int k = 1; k <= 3; k++) begin
      tick(1, 1, 2'b00, 16'h0, 0, 0, 0);
      chk($sformatf("thaw_k%0d", k), irq, (k == 3));
    end
    for (int i = 0; i < 3; i++) tick(0, 1, 2'b00, 16'h0, 0, 1, 0);
    chk("cen0_ack_ignored", irq, 1);
    tick(1, 1, 2'b11, 16'h0382, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, 1, 2'b00, 16'h0, 0, 0, 0);
    chk("pre_rst_irq", irq, 1);
    tick(1, 1, 2'b00, 16'h0, 1, 0, 0);
    tick(1, 1, 2'b00, 16'h0, 0, 0, 0);
    rst = 1;
    #1;
    chk("async_rst", {irq, int_lvl, int_addr, dmach, dmaen, dout}, {1'b0, 3'd0, 8'h20, 2'd0, 1'b0, 16'h0});
    m_reset();
    @(posedge clk); @(negedge clk);
    rst = 0;

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      bit [1:0] w;
      bit [15:0] d;
      w = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
      d = {8'($urandom_range(0, 6)), 8'($urandom)};
      tick($urandom_range(0, 4) != 0, $urandom_range(0, 5) != 0, w, d,
           1'($urandom), $urandom_range(0, 6) == 0, $urandom_range(0, 19) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
